// File: rtl/iq_sample_fifo_pkg.sv
// Shared transceiver definitions for the IQ sample FIFO: default widths, the
// packed IQ pair width and the encoding of the per-cycle FIFO operation.
package iq_sample_fifo_pkg;

  localparam int IQ_W_DEF       = 16;
  localparam int DEPTH_LOG2_DEF = 4;
  localparam int IQ_PAIR_W_DEF  = 2 * IQ_W_DEF;

  // One I/Q pair is stored as a single word: I in the upper half, Q in the lower half.
  function automatic int pair_width(input int iq_w);
    return 2 * iq_w;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/iq_sample_fifo_if.sv
// Port bundle between the FIFO pointer/flag control and its sample storage.
interface iq_sample_fifo_if
  import iq_sample_fifo_pkg::*;
#(
  parameter int AW = DEPTH_LOG2_DEF,
  parameter int DW = IQ_PAIR_W_DEF
) ();

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport ctrl (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data
  );

  modport mem (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data
  );

endinterface

// File: rtl/iq_fifo_ram.sv
// Simple dual-port IQ pair storage: synchronous write, registered read-first
// read port whose output register holds its value until the next read.
module iq_fifo_ram
  import iq_sample_fifo_pkg::*;
#(
  parameter int AW = DEPTH_LOG2_DEF,
  parameter int DW = IQ_PAIR_W_DEF
) (
  input logic            clk,
  input logic            rst,
  iq_sample_fifo_if.mem  bus
);

  logic [DW-1:0] mem_r [0:(1 << AW) - 1];

  // Write port: storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem_r[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Read port with synchronously reset output register; a same-address write
  // in the same cycle returns the old word, which the full-FIFO push+pop relies on.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rd_data <= {DW{1'b0}};
    end else if (bus.rd_en) begin
      bus.rd_data <= mem_r[bus.rd_addr];
    end else begin
      bus.rd_data <= bus.rd_data;
    end
  end

endmodule

// File: rtl/iq_sample_fifo.sv
// IQ sample FIFO between the DDC output and the STM32 nibble interface: pointer,
// level and sticky flag control around the iq_fifo_ram storage.
module iq_sample_fifo
  import iq_sample_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int IQ_W       = IQ_W_DEF
) (
  input  logic                  clk_in,
  input  logic                  rst,
  input  logic [IQ_W-1:0]       I_in,
  input  logic [IQ_W-1:0]       Q_in,
  input  logic                  iq_valid,
  input  logic                  rd_req,
  output logic [IQ_W-1:0]       I_out,
  output logic [IQ_W-1:0]       Q_out,
  output logic                  out_valid,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_flags
);

  localparam int                  PAIR_W   = pair_width(IQ_W);
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0] LVL_ZERO = {(DEPTH_LOG2 + 1){1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic [DEPTH_LOG2:0]   level_s;
  logic                  empty_r;
  logic                  full_r;
  logic                  out_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  ovf_evt_s;
  logic                  udf_evt_s;
  fifo_op_e              op_s;

  iq_sample_fifo_if #(.AW(DEPTH_LOG2), .DW(PAIR_W)) ram_bus ();

  iq_fifo_ram #(
    .AW (DEPTH_LOG2),
    .DW (PAIR_W)
  ) u_ram (
    .clk (clk_in),
    .rst (rst),
    .bus (ram_bus)
  );

  // Decide this cycle's push/pop; a pop on a full FIFO frees the slot for the push,
  // while a pop on an empty FIFO is refused even if a push arrives together.
  always_comb begin
    pop_s     = rd_req & ~empty_r;
    push_s    = iq_valid & (~full_r | pop_s);
    ovf_evt_s = iq_valid & ~push_s;
    udf_evt_s = rd_req & empty_r;
    op_s      = fifo_op_e'({push_s, pop_s});
    level_s   = level_r;
    case (op_s)
      OP_PUSH: level_s = level_r + LVL_ONE;
      OP_POP:  level_s = level_r - LVL_ONE;
      OP_IDLE: level_s = level_r;
      OP_BOTH: level_s = level_r;
      default: level_s = level_r;
    endcase
    ram_bus.wr_en   = push_s;
    ram_bus.wr_addr = wr_ptr_r;
    ram_bus.wr_data = {I_in, Q_in};
    ram_bus.rd_en   = pop_s;
    ram_bus.rd_addr = rd_ptr_r;
  end

  // Pointer, level, status and sticky flag registers; reset overrides any traffic.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
      level_r     <= LVL_ZERO;
      empty_r     <= 1'b1;
      full_r      <= 1'b0;
      out_valid_r <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
      rd_ptr_r    <= pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
      level_r     <= level_s;
      empty_r     <= (level_s == LVL_ZERO);
      full_r      <= (level_s == LVL_FULL);
      out_valid_r <= pop_s;
      // A fresh event wins over a clear request in the same cycle.
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (clr_flags) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (udf_evt_s) begin
        underflow_r <= 1'b1;
      end else if (clr_flags) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign I_out     = ram_bus.rd_data[PAIR_W-1:IQ_W];
  assign Q_out     = ram_bus.rd_data[IQ_W-1:0];
  assign out_valid = out_valid_r;
  assign empty     = empty_r;
  assign full      = full_r;
  assign level     = level_r;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule
